// File: rtl/neighbor_reward_pkg.sv
// Shared types and RAM map for the neighbor-table / reward engine.
package neighbor_reward_pkg;

  // Controller states
  typedef enum logic [2:0] {
    StIdle,
    StRdHdr,
    StSearch,
    StUpdate,
    StInsert,
    StSkip,
    StCalc,
    StDone
  } state_e;

  // Fixed header words at the bottom of the RAM
  localparam int unsigned OwnIdAddr  = 0;
  localparam int unsigned OwnClAddr  = 1;
  localparam int unsigned NbrCntAddr = 2;

  // Word offsets inside a 4-word neighbor entry
  localparam int unsigned OffId      = 0;
  localparam int unsigned OffBattery = 1;
  localparam int unsigned OffValue   = 2;
  localparam int unsigned OffCluster = 3;

  // Q1.15 battery to Q8.8 alignment
  localparam int unsigned BattShift = 7;

endpackage

// File: rtl/neighbor_reward_calc.sv
// Combinational reward datapath: base = value + (battery >> 7), halved for a foreign cluster.
// Build option: define REWARD_SAT_EN to clamp an overflowing base to all-ones instead of wrapping.
module reward_calc
  import neighbor_reward_pkg::*;
#(
  parameter int unsigned Width = 16
) (
  input  logic [Width-1:0] value_i,
  input  logic [Width-1:0] battery_i,
  input  logic             same_cluster_i,
  output logic [Width-1:0] reward_o
);

`ifdef REWARD_SAT_EN
  logic [Width:0]   sum;
`else
  logic [Width-1:0] sum;
`endif
  logic [Width-1:0] base;

  // Base sum, optional clamp on carry, then cluster halving
  always_comb begin
`ifdef REWARD_SAT_EN
    sum  = {1'b0, value_i} + {1'b0, (battery_i >> BattShift)};
    base = sum[Width] ? '1 : sum[Width-1:0];
`else
    sum  = value_i + (battery_i >> BattShift);
    base = sum;
`endif
    reward_o = same_cluster_i ? base : (base >> 1);
  end

endmodule

// File: rtl/neighbor_reward_top.sv
// Neighbor-table and reward engine. Latches a packet header on en, searches the RAM-resident
// neighbor table, updates or inserts the sender, then produces a Q8.8 reward with a done pulse.
// Build option: REWARD_SAT_EN (see reward_calc).
module neighbor_reward_top
  import neighbor_reward_pkg::*;
#(
  parameter int unsigned            WORD_WIDTH = 16,
  parameter int unsigned            ADDR_WIDTH = 11,
  parameter int unsigned            MAX_NBR    = 16,
  parameter logic [ADDR_WIDTH-1:0]  TABLE_BASE = 11'h010
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  en,
  output logic [ADDR_WIDTH-1:0] address,
  output logic                  wr_en,
  output logic [WORD_WIDTH-1:0] mem_data_in,
  input  logic [WORD_WIDTH-1:0] mem_data_out,
  input  logic [WORD_WIDTH-1:0] fsourceID,
  input  logic [WORD_WIDTH-1:0] fbatteryStat,
  input  logic [WORD_WIDTH-1:0] fValue,
  input  logic [WORD_WIDTH-1:0] fclusterID,
  input  logic [WORD_WIDTH-1:0] fdestinationID,
  output logic [WORD_WIDTH-1:0] reward_out,
  output logic                  done_reward
);

  // Wide enough to hold MAX_NBR + 1 (search runs one index ahead of the compare)
  localparam int unsigned IdxW = $clog2(MAX_NBR + 1) + 1;

  state_e                state_q, state_d;
  logic [2:0]            step_q, step_d;
  logic [IdxW-1:0]       idx_q, idx_d;
  logic [IdxW-1:0]       match_q, match_d;
  logic [WORD_WIDTH-1:0] own_id_q, own_id_d;
  logic [WORD_WIDTH-1:0] own_cl_q, own_cl_d;
  logic [WORD_WIDTH-1:0] n_q, n_d;
  logic [ADDR_WIDTH-1:0] address_q, address_d;
  logic                  wr_en_q, wr_en_d;
  logic [WORD_WIDTH-1:0] wdata_q, wdata_d;
  logic [WORD_WIDTH-1:0] reward_q, reward_d;
  logic                  done_q, done_d;

  logic                  lat_load;
  logic [WORD_WIDTH-1:0] src_q, batt_q, val_q, cl_q, dst_q;

  logic [IdxW-1:0]       k;
  logic [IdxW-1:0]       ins_idx;
  logic                  end_of_list;
  logic [WORD_WIDTH-1:0] calc_reward;

  function automatic logic [ADDR_WIDTH-1:0] entry_addr(input logic [IdxW-1:0] i,
                                                       input int unsigned off);
    return TABLE_BASE + ADDR_WIDTH'({i, 2'b00}) + ADDR_WIDTH'(off);
  endfunction

  // Entry whose ID word is on mem_data_out during a search compare cycle
  assign k           = idx_q - IdxW'(1);
  assign ins_idx     = IdxW'(n_q);
  assign end_of_list = (WORD_WIDTH'(k) >= n_q) || (k >= IdxW'(MAX_NBR));

  reward_calc #(
    .Width (WORD_WIDTH)
  ) u_reward_calc (
    .value_i        (val_q),
    .battery_i      (batt_q),
    .same_cluster_i (cl_q == own_cl_q),
    .reward_o       (calc_reward)
  );

  // Packet header capture on the accepted start request
  always_ff @(posedge clock or posedge nrst) begin
    if (nrst) begin
      src_q  <= '0;
      batt_q <= '0;
      val_q  <= '0;
      cl_q   <= '0;
      dst_q  <= '0;
    end else if (lat_load) begin
      src_q  <= fsourceID;
      batt_q <= fbatteryStat;
      val_q  <= fValue;
      cl_q   <= fclusterID;
      dst_q  <= fdestinationID;
    end
  end

  // Controller and registered RAM/result outputs
  always_ff @(posedge clock or posedge nrst) begin
    if (nrst) begin
      state_q   <= StIdle;
      step_q    <= '0;
      idx_q     <= '0;
      match_q   <= '0;
      own_id_q  <= '0;
      own_cl_q  <= '0;
      n_q       <= '0;
      address_q <= '0;
      wr_en_q   <= 1'b0;
      wdata_q   <= '0;
      reward_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      idx_q     <= idx_d;
      match_q   <= match_d;
      own_id_q  <= own_id_d;
      own_cl_q  <= own_cl_d;
      n_q       <= n_d;
      address_q <= address_d;
      wr_en_q   <= wr_en_d;
      wdata_q   <= wdata_d;
      reward_q  <= reward_d;
      done_q    <= done_d;
    end
  end

  // Next-state logic. Reads return two cycles after address_d is set, so the header and
  // the table walk are pipelined one issue ahead of the compare.
  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    idx_d     = idx_q;
    match_d   = match_q;
    own_id_d  = own_id_q;
    own_cl_d  = own_cl_q;
    n_d       = n_q;
    address_d = address_q;
    wr_en_d   = 1'b0;
    wdata_d   = wdata_q;
    reward_d  = reward_q;
    done_d    = 1'b0;
    lat_load  = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (en) begin
          lat_load  = 1'b1;
          address_d = ADDR_WIDTH'(OwnIdAddr);
          step_d    = '0;
          state_d   = StRdHdr;
        end
      end

      StRdHdr: begin
        step_d = step_q + 3'd1;
        unique case (step_q)
          3'd0: address_d = ADDR_WIDTH'(OwnClAddr);
          3'd1: begin
            address_d = ADDR_WIDTH'(NbrCntAddr);
            own_id_d  = mem_data_out;
          end
          3'd2: begin
            // Speculative read of entry 0 ID; harmless if the table is empty
            address_d = entry_addr('0, OffId);
            own_cl_d  = mem_data_out;
          end
          default: begin
            n_d    = mem_data_out;
            idx_d  = IdxW'(1);
            step_d = '0;
            if ((dst_q == own_id_q) || (dst_q == '1)) begin
              state_d = StSearch;
            end else begin
              state_d = StCalc;
            end
          end
        endcase
      end

      StSearch: begin
        if (step_q[0]) begin
          step_d = '0;
        end else if (end_of_list) begin
          step_d  = '0;
          state_d = (n_q < WORD_WIDTH'(MAX_NBR)) ? StInsert : StSkip;
        end else if (mem_data_out == src_q) begin
          match_d = k;
          step_d  = '0;
          state_d = StUpdate;
        end else begin
          address_d = entry_addr(idx_q, OffId);
          idx_d     = idx_q + IdxW'(1);
          step_d    = 3'd1;
        end
      end

      StUpdate: begin
        wr_en_d = 1'b1;
        step_d  = step_q + 3'd1;
        unique case (step_q)
          3'd0: begin
            address_d = entry_addr(match_q, OffBattery);
            wdata_d   = batt_q;
          end
          3'd1: begin
            address_d = entry_addr(match_q, OffValue);
            wdata_d   = val_q;
          end
          default: begin
            address_d = entry_addr(match_q, OffCluster);
            wdata_d   = cl_q;
            state_d   = StCalc;
          end
        endcase
      end

      StInsert: begin
        wr_en_d = 1'b1;
        step_d  = step_q + 3'd1;
        unique case (step_q)
          3'd0: begin
            address_d = entry_addr(ins_idx, OffId);
            wdata_d   = src_q;
          end
          3'd1: begin
            address_d = entry_addr(ins_idx, OffBattery);
            wdata_d   = batt_q;
          end
          3'd2: begin
            address_d = entry_addr(ins_idx, OffValue);
            wdata_d   = val_q;
          end
          3'd3: begin
            address_d = entry_addr(ins_idx, OffCluster);
            wdata_d   = cl_q;
          end
          default: begin
            address_d = ADDR_WIDTH'(NbrCntAddr);
            wdata_d   = n_q + WORD_WIDTH'(1);
            state_d   = StCalc;
          end
        endcase
      end

      StSkip: state_d = StCalc;

      StCalc: begin
        reward_d = calc_reward;
        done_d   = 1'b1;
        state_d  = StDone;
      end

      StDone: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  assign address     = address_q;
  assign wr_en       = wr_en_q;
  assign mem_data_in = wdata_q;
  assign reward_out  = reward_q;
  assign done_reward = done_q;

endmodule

// File: tb/tb_neighbor_reward_top.sv
// Directed self-checking bench for neighbor_reward_top with a behavioural registered RAM.
module tb_neighbor_reward_top;

  logic        clock;
  logic        nrst;
  logic        en;
  logic [10:0] address;
  logic        wr_en;
  logic [15:0] mem_data_in;
  logic [15:0] mem_data_out;
  logic [15:0] fsourceID, fbatteryStat, fValue, fclusterID, fdestinationID;
  logic [15:0] reward_out;
  logic        done_reward;

  logic [15:0] mem [0:2047];

  int checks;
  int errors;
  int wr_count;
  int done_count;
  int lat;
  logic seen;

`ifdef REWARD_SAT_EN
  localparam logic [15:0] SatExp = 16'hFFFF;
`else
  localparam logic [15:0] SatExp = 16'h0040;
`endif

  neighbor_reward_top dut (
    .clock          (clock),
    .nrst           (nrst),
    .en             (en),
    .address        (address),
    .wr_en          (wr_en),
    .mem_data_in    (mem_data_in),
    .mem_data_out   (mem_data_out),
    .fsourceID      (fsourceID),
    .fbatteryStat   (fbatteryStat),
    .fValue         (fValue),
    .fclusterID     (fclusterID),
    .fdestinationID (fdestinationID),
    .reward_out     (reward_out),
    .done_reward    (done_reward)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single-port RAM, registered read
  always @(posedge clock) begin
    if (wr_en) mem[address] <= mem_data_in;
    mem_data_out <= mem[address];
  end

  // Activity counters sampled mid-cycle
  always @(negedge clock) begin
    if (wr_en) wr_count++;
    if (done_reward) done_count++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [15:0] n);
    mem[0] = 16'd3;
    mem[1] = 16'd1;
    mem[2] = n;
    for (int i = 16'h010; i < 16'h060; i++) mem[i] = 16'h0000;
  endtask

  // Pulses en for one cycle; returns at the negedge one cycle after the latch edge
  task automatic start_pkt(input logic [15:0] src, input logic [15:0] batt,
                           input logic [15:0] val, input logic [15:0] cl,
                           input logic [15:0] dst);
    @(negedge clock);
    wr_count       = 0;
    done_count     = 0;
    fsourceID      = src;
    fbatteryStat   = batt;
    fValue         = val;
    fclusterID     = cl;
    fdestinationID = dst;
    en             = 1'b1;
    @(negedge clock);
    en             = 1'b0;
    fsourceID      = 16'hDEAD;
    fbatteryStat   = 16'hBEEF;
    fValue         = 16'h1234;
    fclusterID     = 16'h0009;
    fdestinationID = 16'h0055;
  endtask

  // lat counts cycles from the en cycle to the done cycle
  task automatic wait_done(input int bound);
    lat  = 1;
    seen = 1'b0;
    while (!seen && lat < bound) begin
      @(negedge clock);
      lat++;
      if (done_reward) seen = 1'b1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    nrst = 1'b1;
    en = 1'b0;
    fsourceID = '0;
    fbatteryStat = '0;
    fValue = '0;
    fclusterID = '0;
    fdestinationID = '0;
    repeat (3) @(negedge clock);
    check("rst_address", 32'(address), 32'h0);
    check("rst_wr_en", 32'(wr_en), 32'h0);
    check("rst_wdata", 32'(mem_data_in), 32'h0);
    check("rst_reward", 32'(reward_out), 32'h0);
    check("rst_done", 32'(done_reward), 32'h0);
    nrst = 1'b0;
    repeat (2) @(negedge clock);

    // New neighbor into an empty table
    preload(16'd0);
    start_pkt(16'd15, 16'h4000, 16'h0680, 16'd1, 16'd3);
    wait_done(200);
    check("new_done_seen", 32'(seen), 32'h1);
    check("new_latency_ok", 32'(lat <= 12), 32'h1);
    check("new_reward", 32'(reward_out), 32'h0700);
    repeat (3) @(negedge clock);
    check("new_done_pulses", 32'(done_count), 32'h1);
    check("new_wr_count", 32'(wr_count), 32'h5);
    check("new_id", 32'(mem[16'h010]), 32'd15);
    check("new_batt", 32'(mem[16'h011]), 32'h4000);
    check("new_val", 32'(mem[16'h012]), 32'h0680);
    check("new_cl", 32'(mem[16'h013]), 32'h1);
    check("new_n", 32'(mem[2]), 32'h1);
    check("new_reward_hold", 32'(reward_out), 32'h0700);

    // Existing neighbor gets refreshed in place
    preload(16'd1);
    mem[16'h010] = 16'd1;
    start_pkt(16'd1, 16'h2000, 16'h0680, 16'd1, 16'd3);
    wait_done(200);
    check("upd_done_seen", 32'(seen), 32'h1);
    check("upd_latency_ok", 32'(lat <= 14), 32'h1);
    check("upd_reward", 32'(reward_out), 32'h06C0);
    repeat (3) @(negedge clock);
    check("upd_wr_count", 32'(wr_count), 32'h3);
    check("upd_id", 32'(mem[16'h010]), 32'h1);
    check("upd_batt", 32'(mem[16'h011]), 32'h2000);
    check("upd_val", 32'(mem[16'h012]), 32'h0680);
    check("upd_cl", 32'(mem[16'h013]), 32'h1);
    check("upd_n", 32'(mem[2]), 32'h1);
    check("upd_no_entry1", 32'(mem[16'h014]), 32'h0);

    // Foreign cluster halves the reward
    preload(16'd0);
    start_pkt(16'd15, 16'h4000, 16'h0680, 16'd2, 16'd3);
    wait_done(200);
    check("for_done_seen", 32'(seen), 32'h1);
    check("for_reward", 32'(reward_out), 32'h0380);
    repeat (3) @(negedge clock);
    check("for_cl", 32'(mem[16'h013]), 32'h2);
    check("for_n", 32'(mem[2]), 32'h1);

    // Not addressed to us: no table writes
    preload(16'd0);
    start_pkt(16'd15, 16'h4000, 16'h0680, 16'd1, 16'd7);
    wait_done(200);
    check("dst7_done_seen", 32'(seen), 32'h1);
    check("dst7_reward", 32'(reward_out), 32'h0700);
    repeat (3) @(negedge clock);
    check("dst7_wr_count", 32'(wr_count), 32'h0);
    check("dst7_n", 32'(mem[2]), 32'h0);

    // Broadcast destination still updates the table
    preload(16'd0);
    start_pkt(16'd21, 16'h4000, 16'h0680, 16'd1, 16'hFFFF);
    wait_done(200);
    check("bc_done_seen", 32'(seen), 32'h1);
    repeat (3) @(negedge clock);
    check("bc_id", 32'(mem[16'h010]), 32'd21);
    check("bc_n", 32'(mem[2]), 32'h1);

    // Full table, no match: skip
    preload(16'd16);
    for (int i = 0; i < 16; i++) mem[16'h010 + 4 * i] = 16'(100 + i);
    start_pkt(16'd15, 16'h4000, 16'h0680, 16'd1, 16'd3);
    wait_done(200);
    check("full_done_seen", 32'(seen), 32'h1);
    check("full_latency_ok", 32'(lat <= 44), 32'h1);
    check("full_reward", 32'(reward_out), 32'h0700);
    repeat (3) @(negedge clock);
    check("full_wr_count", 32'(wr_count), 32'h0);
    check("full_n", 32'(mem[2]), 32'd16);

    // Base overflow
    preload(16'd0);
    start_pkt(16'd15, 16'h4000, 16'hFFC0, 16'd1, 16'd3);
    wait_done(200);
    check("sat_done_seen", 32'(seen), 32'h1);
    check("sat_reward", 32'(reward_out), 32'(SatExp));

    // Reset in the middle of a table walk
    preload(16'd16);
    for (int i = 0; i < 16; i++) mem[16'h010 + 4 * i] = 16'(100 + i);
    start_pkt(16'd15, 16'h4000, 16'h0680, 16'd1, 16'd3);
    repeat (8) @(negedge clock);
    nrst = 1'b1;
    #1;
    check("mid_rst_address", 32'(address), 32'h0);
    check("mid_rst_wr_en", 32'(wr_en), 32'h0);
    check("mid_rst_wdata", 32'(mem_data_in), 32'h0);
    check("mid_rst_reward", 32'(reward_out), 32'h0);
    check("mid_rst_done", 32'(done_reward), 32'h0);
    @(negedge clock);
    nrst = 1'b0;
    check("mid_rst_n_kept", 32'(mem[2]), 32'd16);
    @(negedge clock);

    // Normal run after reset, with a second en while busy
    preload(16'd0);
    start_pkt(16'd15, 16'h4000, 16'h0680, 16'd1, 16'd3);
    repeat (2) @(negedge clock);
    fsourceID      = 16'd9;
    fbatteryStat   = 16'h0000;
    fValue         = 16'h1000;
    fclusterID     = 16'd2;
    fdestinationID = 16'd3;
    en             = 1'b1;
    @(negedge clock);
    en             = 1'b0;
    wait_done(200);
    check("post_done_seen", 32'(seen), 32'h1);
    check("post_reward", 32'(reward_out), 32'h0700);
    repeat (25) @(negedge clock);
    check("post_done_pulses", 32'(done_count), 32'h1);
    check("post_wr_count", 32'(wr_count), 32'h5);
    check("post_id", 32'(mem[16'h010]), 32'd15);
    check("post_n", 32'(mem[2]), 32'h1);
    check("post_reward_hold", 32'(reward_out), 32'h0700);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
